// File: rtl/sort_chk_pkg.sv
// rtl/sort_chk_pkg.sv - shared types and width helper for the sort stream checker
// Optional packet sum output is enabled by SORT_CHK_SUM_EN (see sort_stream_checker).
package sort_chk_pkg;

  // Length counter must hold MAX_PKT_LEN+1 so overlength packets stay distinguishable.
  function automatic int len_width(input int max_len);
    return $clog2(max_len + 2);
  endfunction

  localparam int LEN_W = len_width(16);

  typedef enum logic [1:0] {
    IDLE,
    RECV,
    REPORT
  } state_t;

  typedef struct packed {
    logic [LEN_W-1:0] len;
    logic             order_err;
    logic             sop_err;
    logic             len_err;
  } pkt_status_t;

endpackage

// File: rtl/sort_stream_checker_sat_counter.sv
// rtl/sort_stream_checker_sat_counter.sv - event counter, saturating or wrapping
module sat_counter #(
  parameter int WIDTH    = 16,
  parameter bit SATURATE = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (inc && !(SATURATE && (&count))) begin
      count <= count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/sort_stream_checker.sv
// rtl/sort_stream_checker.sv - Avalon-ST sink that checks packet order, framing and length
// Define SORT_CHK_SUM_EN to add pkt_sum_o, the modular sum of each packet's beats.
module sort_stream_checker
  import sort_chk_pkg::*;
#(
  parameter int DWIDTH      = 8,
  parameter int MAX_PKT_LEN = 16,
  parameter int CWIDTH      = 16,
  localparam int LWIDTH     = len_width(MAX_PKT_LEN)
`ifdef SORT_CHK_SUM_EN
  ,
  localparam int SWIDTH     = DWIDTH + $clog2(MAX_PKT_LEN + 1)
`endif
) (
  input  logic              clk_i,
  input  logic              arst_i,
  input  logic [DWIDTH-1:0] snk_data_i,
  input  logic              snk_startofpacket_i,
  input  logic              snk_endofpacket_i,
  input  logic              snk_valid_i,
  output logic              snk_ready_o,
  output logic              pkt_done_o,
  output logic [LWIDTH-1:0] pkt_len_o,
  output logic              pkt_order_err_o,
  output logic              pkt_sop_err_o,
  output logic              pkt_len_err_o,
  output logic              stray_o,
  output logic [CWIDTH-1:0] pkt_cnt_o,
  output logic [CWIDTH-1:0] err_cnt_o
`ifdef SORT_CHK_SUM_EN
  ,
  output logic [SWIDTH-1:0] pkt_sum_o
`endif
);

  localparam logic [LWIDTH-1:0] LEN_SAT = LWIDTH'(MAX_PKT_LEN + 1);
  localparam logic [LWIDTH-1:0] LEN_MAX = LWIDTH'(MAX_PKT_LEN);

  state_t            state_q, state_d;
  logic              ready_q;
  logic              accept;
  logic [LWIDTH-1:0] len_q, len_nx;
  logic              order_q, order_nx;
  logic              sop_q, sop_nx;
  logic [DWIDTH-1:0] prev_q;
  logic              stray_ev, stray_q;
  logic              finish;
  logic              err_inc;
  pkt_status_t       record, status_q;

  assign accept = snk_valid_i && ready_q;

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept && snk_startofpacket_i)
                 state_d = snk_endofpacket_i ? REPORT : RECV;
      RECV:    if (accept && snk_endofpacket_i) state_d = REPORT;
      REPORT:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Next packet flags including the current beat, so the record can be
  // captured on the same edge that accepts EOP.
  always_comb begin
    len_nx   = len_q;
    order_nx = order_q;
    sop_nx   = sop_q;
    stray_ev = 1'b0;
    finish   = 1'b0;
    if (state_q == IDLE && accept) begin
      if (snk_startofpacket_i) begin
        len_nx   = LWIDTH'(1);
        order_nx = 1'b0;
        sop_nx   = 1'b0;
        finish   = snk_endofpacket_i;
      end else begin
        stray_ev = 1'b1;
      end
    end else if (state_q == RECV && accept) begin
      len_nx   = (len_q == LEN_SAT) ? len_q : len_q + LWIDTH'(1);
      order_nx = order_q | (snk_data_i < prev_q);
      sop_nx   = sop_q | snk_startofpacket_i;
      finish   = snk_endofpacket_i;
    end
    record           = '0;
    record.len       = LEN_W'(len_nx);
    record.order_err = order_nx;
    record.sop_err   = sop_nx;
    record.len_err   = (len_nx > LEN_MAX);
  end

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      ready_q  <= 1'b1;
      stray_q  <= 1'b0;
      len_q    <= '0;
      order_q  <= 1'b0;
      sop_q    <= 1'b0;
      prev_q   <= '0;
      status_q <= '0;
    end else begin
      ready_q <= (state_d != REPORT);
      stray_q <= stray_ev;
      if (state_q == REPORT) begin
        len_q   <= '0;
        order_q <= 1'b0;
        sop_q   <= 1'b0;
      end else begin
        len_q   <= len_nx;
        order_q <= order_nx;
        sop_q   <= sop_nx;
      end
      if (accept) prev_q <= snk_data_i;
      if (finish) status_q <= record;
    end
  end

`ifdef SORT_CHK_SUM_EN
  logic [SWIDTH-1:0] sum_q, sum_nx, sum_rec_q;

  always_comb begin
    sum_nx = sum_q;
    if (state_q == IDLE && accept && snk_startofpacket_i)
      sum_nx = SWIDTH'(snk_data_i);
    else if (state_q == RECV && accept)
      sum_nx = sum_q + SWIDTH'(snk_data_i);
  end

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      sum_q     <= '0;
      sum_rec_q <= '0;
    end else begin
      sum_q <= (state_q == REPORT) ? '0 : sum_nx;
      if (finish) sum_rec_q <= sum_nx;
    end
  end

  assign pkt_sum_o = sum_rec_q;
`endif

  assign err_inc = stray_ev ||
                   (finish && (record.order_err || record.sop_err || record.len_err));

  sat_counter #(.WIDTH(CWIDTH), .SATURATE(1'b0)) u_pkt_cnt (
    .clk   (clk_i),
    .rst   (arst_i),
    .inc   (finish),
    .count (pkt_cnt_o)
  );

  sat_counter #(.WIDTH(CWIDTH), .SATURATE(1'b1)) u_err_cnt (
    .clk   (clk_i),
    .rst   (arst_i),
    .inc   (err_inc),
    .count (err_cnt_o)
  );

  assign snk_ready_o     = ready_q;
  assign pkt_done_o      = (state_q == REPORT);
  assign pkt_len_o       = status_q.len[LWIDTH-1:0];
  assign pkt_order_err_o = status_q.order_err;
  assign pkt_sop_err_o   = status_q.sop_err;
  assign pkt_len_err_o   = status_q.len_err;
  assign stray_o         = stray_q;

endmodule

// File: tb/tb_sort_stream_checker.sv
// tb/tb_sort_stream_checker.sv - directed self-checking bench for sort_stream_checker
// Compile with SORT_CHK_SUM_EN defined to also check pkt_sum_o.
module tb_sort_stream_checker;

  logic        clk = 1'b0;
  logic        arst = 1'b1;
  logic [7:0]  data = '0;
  logic        sop = 1'b0;
  logic        eop = 1'b0;
  logic        valid = 1'b0;
  logic        snk_ready_o;
  logic        pkt_done_o;
  logic [4:0]  pkt_len_o;
  logic        pkt_order_err_o;
  logic        pkt_sop_err_o;
  logic        pkt_len_err_o;
  logic        stray_o;
  logic [15:0] pkt_cnt_o;
  logic [15:0] err_cnt_o;
`ifdef SORT_CHK_SUM_EN
  logic [12:0] pkt_sum_o;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  sort_stream_checker dut (
    .clk_i               (clk),
    .arst_i              (arst),
    .snk_data_i          (data),
    .snk_startofpacket_i (sop),
    .snk_endofpacket_i   (eop),
    .snk_valid_i         (valid),
    .snk_ready_o         (snk_ready_o),
    .pkt_done_o          (pkt_done_o),
    .pkt_len_o           (pkt_len_o),
    .pkt_order_err_o     (pkt_order_err_o),
    .pkt_sop_err_o       (pkt_sop_err_o),
    .pkt_len_err_o       (pkt_len_err_o),
    .stray_o             (stray_o),
    .pkt_cnt_o           (pkt_cnt_o),
    .err_cnt_o           (err_cnt_o)
`ifdef SORT_CHK_SUM_EN
    ,
    .pkt_sum_o           (pkt_sum_o)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Drive one beat at a falling edge and hold it until the rising edge that accepts it.
  task automatic send(input logic [7:0] d, input logic s, input logic e);
    int n;
    n = 0;
    @(negedge clk);
    data = d; sop = s; eop = e; valid = 1'b1;
    while (!snk_ready_o && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("ready_wait", snk_ready_o, 1);
    @(posedge clk);
    #1;
    valid = 1'b0; sop = 1'b0; eop = 1'b0;
  endtask

  // Called right after the EOP beat: the record must be valid in the next cycle only.
  task automatic check_record(input string tag, input int len, input logic o, input logic s,
                              input logic l, input int pcnt, input int ecnt, input int sum);
    @(negedge clk);
    chk({tag, "_done"}, pkt_done_o, 1);
    chk({tag, "_ready_low"}, snk_ready_o, 0);
    chk({tag, "_len"}, pkt_len_o, len);
    chk({tag, "_order"}, pkt_order_err_o, o);
    chk({tag, "_sop"}, pkt_sop_err_o, s);
    chk({tag, "_lenerr"}, pkt_len_err_o, l);
    chk({tag, "_pkt_cnt"}, pkt_cnt_o, pcnt);
    chk({tag, "_err_cnt"}, err_cnt_o, ecnt);
`ifdef SORT_CHK_SUM_EN
    chk({tag, "_sum"}, pkt_sum_o, sum);
`else
    if (sum < 0) $display("unused sum %0d", sum);
`endif
    @(negedge clk);
    chk({tag, "_done_low"}, pkt_done_o, 0);
    chk({tag, "_ready_back"}, snk_ready_o, 1);
    chk({tag, "_len_hold"}, pkt_len_o, len);
  endtask

  initial begin
    #12;
    chk("rst_ready", snk_ready_o, 1);
    chk("rst_done", pkt_done_o, 0);
    chk("rst_len", pkt_len_o, 0);
    chk("rst_errs", {pkt_order_err_o, pkt_sop_err_o, pkt_len_err_o}, 0);
    chk("rst_stray", stray_o, 0);
    chk("rst_pkt_cnt", pkt_cnt_o, 0);
    chk("rst_err_cnt", err_cnt_o, 0);
    @(negedge clk);
    arst = 1'b0;

    // sorted packet with a repeated value
    send(8'd1, 1, 0);
    send(8'd3, 0, 0);
    send(8'd3, 0, 0);
    send(8'd7, 0, 0);
    send(8'd200, 0, 1);
    check_record("sorted", 5, 0, 0, 0, 1, 0, 214);

    // unsorted packet
    send(8'd5, 1, 0);
    send(8'd4, 0, 0);
    send(8'd9, 0, 1);
    check_record("unsorted", 3, 1, 0, 0, 2, 1, 18);

    // single beat
    send(8'h00, 1, 1);
    check_record("single", 1, 0, 0, 0, 3, 1, 0);

    // 18 ascending beats, extra SOP on the fourth beat
    for (int i = 0; i < 18; i++)
      send(8'(i), (i == 0) || (i == 3), i == 17);
    check_record("overlen", 17, 0, 1, 1, 4, 2, 153);

    // two stray beats in IDLE
    send(8'd50, 0, 0);
    @(negedge clk);
    chk("stray1_pulse", stray_o, 1);
    chk("stray1_err_cnt", err_cnt_o, 3);
    chk("stray1_done", pkt_done_o, 0);
    send(8'd60, 0, 1);
    @(negedge clk);
    chk("stray2_pulse", stray_o, 1);
    chk("stray2_err_cnt", err_cnt_o, 4);
    chk("stray2_done", pkt_done_o, 0);
    chk("stray2_pkt_cnt", pkt_cnt_o, 4);
    @(negedge clk);
    chk("stray_pulse_end", stray_o, 0);

    // reset mid-packet, asserted between clock edges
    send(8'd10, 1, 0);
    send(8'd11, 0, 0);
    send(8'd12, 0, 0);
    #3;
    arst = 1'b1;
    #1;
    chk("midrst_pkt_cnt", pkt_cnt_o, 0);
    chk("midrst_err_cnt", err_cnt_o, 0);
    chk("midrst_len", pkt_len_o, 0);
    chk("midrst_errs", {pkt_order_err_o, pkt_sop_err_o, pkt_len_err_o}, 0);
    chk("midrst_done", pkt_done_o, 0);
    chk("midrst_ready", snk_ready_o, 1);
    @(negedge clk);
    arst = 1'b0;
    send(8'd2, 1, 0);
    send(8'd2, 0, 1);
    check_record("after_rst", 2, 0, 0, 0, 1, 0, 4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "bench timeout");
  end

endmodule

// File: doc/sort_stream_checker.md
Name: sort_stream_checker

Overview:
- Avalon-ST receiver for the sorter's source port. It consumes packets, checks per packet that the data is non-decreasing (unsigned) and that framing and length are correct, and reports one status record per packet.
- Used as an in-fabric self-check behind the sort block and as a bench/board monitor; pairs with the existing sorter the way a receiver pairs with its transmitter.

Parameters:
- DWIDTH, 8, data beat width.
- MAX_PKT_LEN, 16, largest legal packet length in beats.
- CWIDTH, 16, width of the packet and error counters.

Ports:
- clk_i  in  1  clock.
- arst_i  in  1  reset, asynchronous, active-high.
- snk_data_i  in  DWIDTH  beat data.
- snk_startofpacket_i  in  1  SOP.
- snk_endofpacket_i  in  1  EOP.
- snk_valid_i  in  1  beat valid.
- snk_ready_o  out  1  sink ready.
- pkt_done_o  out  1  one-cycle pulse: a status record is valid.
- pkt_len_o  out  LWIDTH=$clog2(MAX_PKT_LEN+2)  beats received, saturating at MAX_PKT_LEN+1.
- pkt_order_err_o  out  1  at least one beat was smaller than its predecessor.
- pkt_sop_err_o  out  1  SOP seen after the first beat.
- pkt_len_err_o  out  1  length exceeded MAX_PKT_LEN.
- stray_o  out  1  one-cycle pulse: a beat arrived outside a packet.
- pkt_cnt_o  out  CWIDTH  packets completed; wraps.
- err_cnt_o  out  CWIDTH  bad packets plus stray beats; saturates at all-ones.

Behaviour:
- One clock; reset is asynchronous and active-high on arst_i. Every flop clears immediately on assertion.
- Reset values: state IDLE, snk_ready_o=1, all pulses 0, all status 0, counters 0.
- A beat is accepted when snk_valid_i && snk_ready_o.
- snk_ready_o=1 in IDLE and RECV, and 0 in REPORT. It is registered and decoded from state.
- State IDLE:
  - Accepted beat with SOP and EOP -> REPORT, length 1.
  - Accepted beat with SOP only -> RECV, length 1, prev_data is set to this beat.
  - Accepted beat without SOP -> beat dropped, stray_o pulses the next cycle, err_cnt_o increments, state stays IDLE.
- State RECV, on each accepted beat:
  - Length increments and saturates at MAX_PKT_LEN+1.
  - If snk_data_i < prev_data, set the order flag.
  - prev_data is updated to snk_data_i.
  - If SOP is set, set the sop flag. The beat is still treated as data; there is no restart.
  - If EOP is set -> REPORT.
  - No accepted beat -> stay in RECV; flags hold.
- State REPORT (exactly one cycle):
  - pkt_done_o=1.
  - pkt_len_o and the three err outputs show this packet's values. len_err is set when length > MAX_PKT_LEN.
  - pkt_cnt_o increments, wrapping.
  - err_cnt_o increments once if any flag is set, saturating.
  - Internal flags and length clear. Next state is IDLE.
- Status outputs hold their last record until the next REPORT.
- Latency: EOP accepted in cycle N -> pkt_done_o and record valid in cycle N+1. The next packet can be accepted from cycle N+2.
- Equal adjacent values are legal; only a strict decrease is an error.
- Reset asserted mid-packet: the partial packet is discarded with no report, and counters return to 0.
- Stray pulse and REPORT can never coincide, because stray beats occur only in IDLE.

Optional Feature:
- Macro SORT_CHK_SUM_EN.
- Defined:
  - Extra output pkt_sum_o, width DWIDTH+$clog2(MAX_PKT_LEN+1).
  - It is the modular sum of all beats of the packet, valid with pkt_done_o and held like the other status outputs.
  - The bench compares it with the pre-sort sum to detect lost or corrupted beats.
- Undefined: the port and accumulator are absent; all other behaviour is identical.

Decomposition:
- Package sort_chk_pkg holds:
  - the state enum {IDLE, RECV, REPORT};
  - a packed struct pkt_status_t {len, order_err, sop_err, len_err};
  - a helper function for the LWIDTH calculation.
- One sub-module, sat_counter (width parameter; inc, saturate-or-wrap select). It is instantiated for pkt_cnt_o (wrap mode) and err_cnt_o (saturate mode).
- FSM and datapath stay in the top module.

Test Plan:
- Sorted packet: packet 1,3,3,7,200 with no stalls -> pkt_done_o in the cycle after EOP, len=5, all errs 0, pkt_cnt=1, err_cnt=0.
- Unsorted packet: packet 5,4,9 -> order_err=1, len=3, err_cnt=1. With SORT_CHK_SUM_EN, pkt_sum_o=18.
- Single beat and ready behaviour: single beat with SOP+EOP, value 0x00 -> len=1, no errs. snk_ready_o=0 for exactly one cycle, then 1.
- Overlength packet: 18 beats, MAX_PKT_LEN=16 -> len=17 (saturated), len_err=1. A second SOP at beat 4 in the same packet also sets sop_err=1; err_cnt increments by 1 only.
- Stray beats: 2 beats without SOP while in IDLE -> two stray_o pulses, err_cnt=2, no pkt_done_o, pkt_cnt unchanged.
- Reset mid-packet: assert arst_i after 3 beats, asynchronously between clock edges -> all outputs 0 immediately. A following packet 2,2 reports len=2 with no errs and pkt_cnt=1.
